bpu_gshare_ras: RTL

//  Parametrised branch prediction unit for the fetch stage. Combines a tagged direct-mapped BTB,
//  a gshare PHT, a speculative GHR with checkpoint repair, and a return address stack (RAS).

---
 rtl/bpu_pkg.sv | 26 ++
 rtl/bpu_gshare_ras_if.sv | 39 +++
 rtl/bpu_ras.sv | 40 ++++
 rtl/bpu_gshare_ras.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: control-transfer
// encodings, two-bit counter states and the saturating counter update.
package bpu_pkg;

   typedef enum logic [1:0] {
      BR_JUMP = 2'b00,
      BR_COND = 2'b01,
      BR_CALL = 2'b10,
      BR_RET  = 2'b11
   } br_type_e;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Move a two-bit counter one step towards the resolved direction,
   // holding at the strong ends.
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == ST) ? ST : ctr + 2'd1;
      end
      return (ctr == SNT) ? SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bpu_gshare_ras_if.sv
// Fetch-side prediction and execute-side resolution bundle between the
// pipeline (master) and the branch prediction unit (slave).
interface bpu_gshare_ras_if #(
   parameter int GHR_W = 8
);
   logic             if_valid;
   logic [31:0]      if_pc;
   logic             if_pred_branch;
   logic             if_pred_taken;
   logic [31:0]      if_pred_npc;
   logic [GHR_W-1:0] if_pred_ghr;

   logic             ex_valid;
   logic [31:0]      ex_pc;
   logic             ex_is_branch;
   logic [1:0]       ex_type;
   logic             ex_is_taken;
   logic [31:0]      ex_target;
   logic             ex_pred_branch;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_npc;
   logic [GHR_W-1:0] ex_pred_ghr;

   logic             flush;

   modport master (
      output if_valid, if_pc,
      output ex_valid, ex_pc, ex_is_branch, ex_type, ex_is_taken, ex_target,
      output ex_pred_branch, ex_pred_taken, ex_pred_npc, ex_pred_ghr,
      input  if_pred_branch, if_pred_taken, if_pred_npc, if_pred_ghr, flush
   );

   modport slave (
      input  if_valid, if_pc,
      input  ex_valid, ex_pc, ex_is_branch, ex_type, ex_is_taken, ex_target,
      input  ex_pred_branch, ex_pred_taken, ex_pred_npc, ex_pred_ghr,
      output if_pred_branch, if_pred_taken, if_pred_npc, if_pred_ghr, flush
   );
endinterface

// File: rtl/bpu_ras.sv
// Circular return address stack. When full, a push overwrites the oldest
// entry and the count holds at the depth; a pop on empty does nothing.
module bpu_ras #(
   parameter int RAS_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [31:0]                push_addr,
   output logic [31:0]                top,
   output logic [$clog2(RAS_DEPTH):0] count
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      stack [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;

   assign top = stack[ptr - PTR_W'(1)];

   // Pointer names the next free slot; count tracks how many entries are trustworthy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (count != CNT_W'(RAS_DEPTH)) count <= count + CNT_W'(1);
      end else if (pop && count != '0) begin
         ptr   <= ptr - PTR_W'(1);
         count <= count - CNT_W'(1);
      end
   end

   // Stack storage needs no reset; the count guards every read.
   always_ff @(posedge clk) begin
      if (push) stack[ptr] <= push_addr;
   end
endmodule

// File: rtl/bpu_gshare_ras.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB, gshare PHT with a
// speculative GHR repaired from EX checkpoints, and a return address stack.
module bpu_gshare_ras
   import bpu_pkg::*;
#(
   parameter int BTB_IDX_W = 8,
   parameter int TAG_W     = 10,
   parameter int GHR_W     = 8,
   parameter int RAS_DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   bpu_gshare_ras_if.slave  bus
);
   localparam int BTB_DEPTH = 1 << BTB_IDX_W;
   localparam int PHT_DEPTH = 1 << GHR_W;

   logic [BTB_DEPTH-1:0] btb_valid;
   logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
   br_type_e             btb_type   [BTB_DEPTH];
   logic [31:0]          btb_target [BTB_DEPTH];
   logic [1:0]           pht        [PHT_DEPTH];
   logic [GHR_W-1:0]     ghr;

   logic [BTB_IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0]     if_tag, ex_tag;
   logic [GHR_W-1:0]     if_pht_idx, ex_pht_idx;
   br_type_e             if_type, ex_kind;
   logic                 hit, pred_taken, flush_int, alias_kill, train;
   logic [31:0]          pred_target, redirect, ras_top;
   logic [$clog2(RAS_DEPTH):0] ras_count;

   assign if_idx     = bus.if_pc[BTB_IDX_W+1:2];
   assign if_tag     = bus.if_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
   assign ex_idx     = bus.ex_pc[BTB_IDX_W+1:2];
   assign ex_tag     = bus.ex_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
   assign if_pht_idx = ghr ^ bus.if_pc[GHR_W+1:2];
   assign ex_pht_idx = bus.ex_pred_ghr ^ bus.ex_pc[GHR_W+1:2];
   assign ex_kind    = br_type_e'(bus.ex_type);
   assign if_type    = btb_type[if_idx];

   assign hit        = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
   assign train      = bus.ex_valid && bus.ex_is_branch;
   assign alias_kill = bus.ex_valid && !bus.ex_is_branch && bus.ex_pred_taken;
   assign redirect   = bus.ex_is_taken ? bus.ex_target : bus.ex_pc + 32'd4;

   // Direction: conditionals follow the PHT, every other hit is taken.
   always_comb begin
      pred_taken = 1'b0;
      if (hit) begin
         if (if_type == BR_COND) pred_taken = pht[if_pht_idx][1];
         else                    pred_taken = 1'b1;
      end
   end

   assign pred_target = (if_type == BR_RET && ras_count != '0) ? ras_top : btb_target[if_idx];

   // Misprediction detect; held low while reset is asserted so the pipe is released at once.
   always_comb begin
      flush_int = 1'b0;
      if (resetn && bus.ex_valid) begin
         if (bus.ex_is_branch)
            flush_int = !bus.ex_pred_branch || (bus.ex_pred_taken != bus.ex_is_taken) ||
                        (bus.ex_is_taken && bus.ex_pred_npc != bus.ex_target);
         else
            flush_int = bus.ex_pred_taken;
      end
   end

   assign bus.flush          = flush_int;
   assign bus.if_pred_branch = hit;
   assign bus.if_pred_taken  = pred_taken;
   assign bus.if_pred_ghr    = ghr;
   assign bus.if_pred_npc    = flush_int  ? redirect :
                               pred_taken ? pred_target : bus.if_pc + 32'd4;

   // GHR: checkpoint repair on flush wins over the speculative shift from IF.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         ghr <= '0;
      else if (flush_int)
         ghr <= (bus.ex_is_branch && ex_kind == BR_COND) ?
                {bus.ex_pred_ghr[GHR_W-2:0], bus.ex_is_taken} : bus.ex_pred_ghr;
      else if (bus.if_valid && hit && if_type == BR_COND)
         ghr <= {ghr[GHR_W-2:0], pred_taken};
   end

   // BTB valid bits: set on training, cleared when a non-branch was predicted taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)         btb_valid <= '0;
      else if (train)      btb_valid[ex_idx] <= 1'b1;
      else if (alias_kill) btb_valid[ex_idx] <= 1'b0;
   end

   // BTB payload is written on every resolved control transfer.
   always_ff @(posedge clk) begin
      if (train) begin
         btb_tag[ex_idx]    <= ex_tag;
         btb_type[ex_idx]   <= ex_kind;
         btb_target[ex_idx] <= bus.ex_target;
      end
   end

   // PHT counters start weakly not-taken and train only on conditionals.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= WNT;
      end else if (train && ex_kind == BR_COND) begin
         pht[ex_pht_idx] <= sat_update(pht[ex_pht_idx], bus.ex_is_taken);
      end
   end

   bpu_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .resetn    (resetn),
      .push      (train && ex_kind == BR_CALL),
      .pop       (train && ex_kind == BR_RET),
      .push_addr (bus.ex_pc + 32'd4),
      .top       (ras_top),
      .count     (ras_count)
   );
endmodule
